// File: rtl/axi4_burst_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_slave_mem
// Description : AXI4 burst slave backed by a word-addressed register array.
//               Independent write and read FSMs share the storage.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH          = 64
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            ERR_STICKY
);

    localparam int                            c_idx_w      = $clog2(MEM_DEPTH);
    localparam int                            c_strb_w     = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] c_beat_bytes = C_S_AXI_ADDR_WIDTH'(c_strb_w);
    localparam logic [2:0]                    c_size_word  = 3'd2;
    localparam logic [1:0]                    c_burst_incr = 2'b01;
    localparam logic [1:0]                    c_resp_okay  = 2'b00;
    localparam logic [1:0]                    c_resp_slv   = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ---------------- write channel state ----------------
    wstate_t                         r_wstate_q, w_wstate_d;
    logic [C_S_AXI_ID_WIDTH-1:0]     r_wid_q, w_wid_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   r_waddr_q, w_waddr_d;
    logic [7:0]                      r_wlen_q, w_wlen_d;
    logic [7:0]                      r_wcnt_q, w_wcnt_d;
    logic [2:0]                      r_wsize_q, w_wsize_d;
    logic [1:0]                      r_wburst_q, w_wburst_d;
    logic                            r_werr_q, w_werr_d;
    logic                            w_awready, w_wready, w_bvalid;
    logic                            w_wbeat_bad, w_mem_we;
    logic [c_idx_w-1:0]              w_widx;

    // ---------------- read channel state -----------------
    rstate_t                         r_rstate_q, w_rstate_d;
    logic [C_S_AXI_ID_WIDTH-1:0]     r_rid_q, w_rid_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   r_raddr_q, w_raddr_d;
    logic [7:0]                      r_rlen_q, w_rlen_d;
    logic [7:0]                      r_rcnt_q, w_rcnt_d;
    logic [2:0]                      r_rsize_q, w_rsize_d;
    logic [1:0]                      r_rburst_q, w_rburst_d;
    logic                            r_rstall_q, w_rstall_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rhold_q, w_rhold_d;
    logic                            w_arready, w_rvalid, w_rbeat_bad;
    logic [c_idx_w-1:0]              w_ridx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_rdata;

    logic                            r_err_sticky_q, w_err_sticky_d;

    // WRAP and reserved burst types both have bit 1 set.
    assign w_widx      = r_waddr_q[2 +: c_idx_w];
    assign w_wbeat_bad = (r_wsize_q != c_size_word) | r_wburst_q[1]
                       | (|r_waddr_q[C_S_AXI_ADDR_WIDTH-1:2+c_idx_w]);
    assign w_mem_we    = S_AXI_WVALID & w_wready & ~w_wbeat_bad;

    always_comb begin
        w_wstate_d = r_wstate_q;
        w_wid_d    = r_wid_q;
        w_waddr_d  = r_waddr_q;
        w_wlen_d   = r_wlen_q;
        w_wcnt_d   = r_wcnt_q;
        w_wsize_d  = r_wsize_q;
        w_wburst_d = r_wburst_q;
        w_werr_d   = r_werr_q;
        w_awready  = 1'b0;
        w_wready   = 1'b0;
        w_bvalid   = 1'b0;
        if (!S_AXI_ARESET) begin
            case (r_wstate_q)
                W_IDLE: begin
                    w_awready = 1'b1;
                    if (S_AXI_AWVALID) begin
                        w_wid_d    = S_AXI_AWID;
                        w_waddr_d  = S_AXI_AWADDR;
                        w_wlen_d   = S_AXI_AWLEN;
                        w_wsize_d  = S_AXI_AWSIZE;
                        w_wburst_d = S_AXI_AWBURST;
                        w_wcnt_d   = 8'd0;
                        w_werr_d   = 1'b0;
                        w_wstate_d = W_DATA;
                    end
                end
                W_DATA: begin
                    w_wready = 1'b1;
                    if (S_AXI_WVALID) begin
                        // The beat counter ends the burst; WLAST is only cross-checked.
                        if (w_wbeat_bad || (S_AXI_WLAST != (r_wcnt_q == r_wlen_q))) begin
                            w_werr_d = 1'b1;
                        end
                        if (r_wburst_q == c_burst_incr) begin
                            w_waddr_d = r_waddr_q + c_beat_bytes;
                        end
                        if (r_wcnt_q == r_wlen_q) begin
                            w_wstate_d = W_RESP;
                        end else begin
                            w_wcnt_d = r_wcnt_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    w_bvalid = 1'b1;
                    if (S_AXI_BREADY) begin
                        w_wstate_d = W_IDLE;
                    end
                end
                default: w_wstate_d = W_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BID     = w_bvalid ? r_wid_q : '0;
    assign S_AXI_BRESP   = (w_bvalid && r_werr_q) ? c_resp_slv : c_resp_okay;

    assign w_ridx      = r_raddr_q[2 +: c_idx_w];
    assign w_rbeat_bad = (r_rsize_q != c_size_word) | r_rburst_q[1]
                       | (|r_raddr_q[C_S_AXI_ADDR_WIDTH-1:2+c_idx_w]);

    always_comb begin
        w_rstate_d = r_rstate_q;
        w_rid_d    = r_rid_q;
        w_raddr_d  = r_raddr_q;
        w_rlen_d   = r_rlen_q;
        w_rcnt_d   = r_rcnt_q;
        w_rsize_d  = r_rsize_q;
        w_rburst_d = r_rburst_q;
        w_arready  = 1'b0;
        w_rvalid   = 1'b0;
        if (!S_AXI_ARESET) begin
            case (r_rstate_q)
                R_IDLE: begin
                    w_arready = 1'b1;
                    if (S_AXI_ARVALID) begin
                        w_rid_d    = S_AXI_ARID;
                        w_raddr_d  = S_AXI_ARADDR;
                        w_rlen_d   = S_AXI_ARLEN;
                        w_rsize_d  = S_AXI_ARSIZE;
                        w_rburst_d = S_AXI_ARBURST;
                        w_rcnt_d   = 8'd0;
                        w_rstate_d = R_DATA;
                    end
                end
                R_DATA: begin
                    w_rvalid = 1'b1;
                    if (S_AXI_RREADY) begin
                        if (r_rburst_q == c_burst_incr) begin
                            w_raddr_d = r_raddr_q + c_beat_bytes;
                        end
                        if (r_rcnt_q == r_rlen_q) begin
                            w_rstate_d = R_IDLE;
                        end else begin
                            w_rcnt_d = r_rcnt_q + 8'd1;
                        end
                    end
                end
                default: w_rstate_d = R_IDLE;
            endcase
        end
    end

    // A concurrent write may change the addressed word during a stall, so the
    // presented data is frozen once the beat has been offered and not taken.
    always_comb begin
        w_rdata = '0;
        if (w_rvalid) begin
            if (r_rstall_q) begin
                w_rdata = r_rhold_q;
            end else if (!w_rbeat_bad) begin
                w_rdata = r_mem[w_ridx];
            end
        end
        w_rstall_d = w_rvalid & ~S_AXI_RREADY;
        w_rhold_d  = w_rdata;
    end

    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RDATA   = w_rdata;
    assign S_AXI_RID     = w_rvalid ? r_rid_q : '0;
    assign S_AXI_RRESP   = (w_rvalid && w_rbeat_bad) ? c_resp_slv : c_resp_okay;
    assign S_AXI_RLAST   = w_rvalid & (r_rcnt_q == r_rlen_q);

    always_comb begin
        w_err_sticky_d = r_err_sticky_q
                       | (w_bvalid & S_AXI_BREADY & r_werr_q)
                       | (w_rvalid & S_AXI_RREADY & w_rbeat_bad);
    end

    assign ERR_STICKY = r_err_sticky_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate_q     <= W_IDLE;
            r_wid_q        <= '0;
            r_waddr_q      <= '0;
            r_wlen_q       <= 8'd0;
            r_wcnt_q       <= 8'd0;
            r_wsize_q      <= 3'd0;
            r_wburst_q     <= 2'd0;
            r_werr_q       <= 1'b0;
            r_rstate_q     <= R_IDLE;
            r_rid_q        <= '0;
            r_raddr_q      <= '0;
            r_rlen_q       <= 8'd0;
            r_rcnt_q       <= 8'd0;
            r_rsize_q      <= 3'd0;
            r_rburst_q     <= 2'd0;
            r_rstall_q     <= 1'b0;
            r_rhold_q      <= '0;
            r_err_sticky_q <= 1'b0;
        end else begin
            r_wstate_q     <= w_wstate_d;
            r_wid_q        <= w_wid_d;
            r_waddr_q      <= w_waddr_d;
            r_wlen_q       <= w_wlen_d;
            r_wcnt_q       <= w_wcnt_d;
            r_wsize_q      <= w_wsize_d;
            r_wburst_q     <= w_wburst_d;
            r_werr_q       <= w_werr_d;
            r_rstate_q     <= w_rstate_d;
            r_rid_q        <= w_rid_d;
            r_raddr_q      <= w_raddr_d;
            r_rlen_q       <= w_rlen_d;
            r_rcnt_q       <= w_rcnt_d;
            r_rsize_q      <= w_rsize_d;
            r_rburst_q     <= w_rburst_d;
            r_rstall_q     <= w_rstall_d;
            r_rhold_q      <= w_rhold_d;
            r_err_sticky_q <= w_err_sticky_d;
        end
    end

    // Storage is deliberately not reset so aborted bursts keep their beats.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    r_mem[w_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_burst_slave_mem
// Description : Directed scoreboard bench for axi4_burst_slave_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  awid = '0, bid, arid = '0, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = 3'd2, arsize = 3'd2;
    logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b1, arvalid = 1'b0, arready;
    logic        rlast, rvalid, rready = 1'b0, err_sticky;

    always #5 clk = ~clk;

    axi4_burst_slave_mem #(
        .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32), .MEM_DEPTH(64)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ERR_STICKY(err_sticky)
    );

    typedef struct packed {logic id; logic [1:0] resp;} bexp_t;
    typedef struct packed {logic id; logic [31:0] data; logic [1:0] resp; logic last;} rexp_t;

    bexp_t exp_b[$];
    rexp_t exp_r[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every B/R handshake and checks R stability.
    bexp_t eb;
    rexp_t er, act_r, stall_val;
    logic  stall_seen = 1'b0;
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected", 64'(1), 64'(0));
            end else begin
                eb = exp_b.pop_front();
                check("b_resp", 64'({bid, bresp}), 64'(eb));
            end
        end
        act_r = {rid, rdata, rresp, rlast};
        if (stall_seen) begin
            check("r_stable", 64'({rvalid, act_r}), 64'({1'b1, stall_val}));
        end
        if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", 64'(1), 64'(0));
            end else begin
                er = exp_r.pop_front();
                check("r_beat", 64'(act_r), 64'(er));
            end
        end
        stall_seen = rvalid && !rready;
        stall_val  = act_r;
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input logic [31:0] base, input logic [3:0] strb,
                            input int early_last, input int abort_after, input int bready_delay,
                            input logic [1:0] exp_resp);
        int t;
        awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awid = id; awvalid = 1'b1;
        if (bready_delay > 0) bready = 1'b0;
        if (abort_after == 0) exp_b.push_back(bexp_t'{id, exp_resp});
        t = 0;
        @(negedge clk);
        while (!awready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("aw_timeout", 64'(0), 64'(1));
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (abort_after != 0 && i == abort_after) break;
            wdata = base + 32'(i);
            wstrb = strb;
            wlast = (early_last >= 0) ? (i == early_last) : (i == int'(len));
            wvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!wready && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) check("w_timeout", 64'(0), 64'(1));
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (abort_after != 0) return;
        for (int k = 0; k < bready_delay; k++) begin
            @(negedge clk);
            check("bvalid_held", 64'(bvalid), 64'(1));
            check("awready_low_in_resp", 64'(awready), 64'(0));
            @(posedge clk); #1;
        end
        bready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("b_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input logic [31:0] base, input logic [31:0] step,
                           input logic [1:0] resp, input bit toggle);
        int t, got;
        for (int i = 0; i <= int'(len); i++)
            exp_r.push_back(rexp_t'{id, base + step * 32'(i), resp, (i == int'(len))});
        araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arid = id; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("ar_timeout", 64'(0), 64'(1));
        @(posedge clk); #1 arvalid = 1'b0;
        got = 0; t = 0;
        while (got <= int'(len) && t < 200) begin
            rready = toggle ? (t % 2 == 0) : 1'b1;
            @(negedge clk);
            if (rvalid && rready) got++;
            @(posedge clk); #1;
            t++;
        end
        rready = 1'b0;
        if (t >= 200) check("r_timeout", 64'(got), 64'(int'(len) + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'({awready, wready, arready}), 64'(0));
        check("rst_valid", 64'({bvalid, rvalid, rlast}), 64'(0));
        check("rst_data", 64'({rdata, rresp, bresp, bid, rid, err_sticky}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'({awready, arready}), 64'(2'b11));
        @(posedge clk); #1;

        // Single INCR burst and read-back
        do_write(32'h0, 8'd7, 2'b01, 1'b1, 32'd1, 4'hF, -1, 0, 0, 2'b00);
        do_read(32'h0, 8'd7, 2'b01, 1'b1, 32'd1, 32'd1, 2'b00, 1'b0);

        // Backpressure on B and R
        do_write(32'h40, 8'd7, 2'b01, 1'b0, 32'h100, 4'hF, -1, 0, 5, 2'b00);
        do_read(32'h40, 8'd7, 2'b01, 1'b0, 32'h100, 32'd1, 2'b00, 1'b1);

        // Byte strobes
        do_write(32'h20, 8'd0, 2'b01, 1'b0, 32'h11223344, 4'hF, -1, 0, 0, 2'b00);
        do_write(32'h20, 8'd0, 2'b01, 1'b0, 32'hAABBCCDD, 4'b0101, -1, 0, 0, 2'b00);
        do_read(32'h20, 8'd0, 2'b01, 1'b0, 32'h11BB33DD, 32'd0, 2'b00, 1'b0);

        // FIXED bursts
        do_write(32'h10, 8'd3, 2'b00, 1'b1, 32'hA, 4'hF, -1, 0, 0, 2'b00);
        do_read(32'h10, 8'd1, 2'b00, 1'b1, 32'hD, 32'd0, 2'b00, 1'b0);
        @(negedge clk);
        check("err_sticky_clean", 64'(err_sticky), 64'(0));
        @(posedge clk); #1;

        // Out of range: last word written, second beat suppressed
        do_write(32'hFC, 8'd1, 2'b01, 1'b0, 32'd5, 4'hF, -1, 0, 0, 2'b10);
        @(negedge clk);
        check("err_sticky_set", 64'(err_sticky), 64'(1));
        @(posedge clk); #1;
        do_read(32'hFC, 8'd0, 2'b01, 1'b0, 32'd5, 32'd0, 2'b00, 1'b0);
        do_read(32'h100, 8'd0, 2'b01, 1'b1, 32'd0, 32'd0, 2'b10, 1'b0);

        // Early WLAST on an AWLEN=3 burst
        do_write(32'h80, 8'd3, 2'b01, 1'b1, 32'h50, 4'hF, 1, 0, 0, 2'b10);

        // Reset after 3 of 8 beats
        do_write(32'hC0, 8'd7, 2'b01, 1'b1, 32'h301, 4'hF, -1, 3, 0, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'({awready, wready, arready}), 64'(0));
        check("midrst_valid", 64'({bvalid, rvalid}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_release", 64'({awready, bvalid, err_sticky}), 64'(3'b100));
        @(posedge clk); #1;
        do_read(32'hC0, 8'd2, 2'b01, 1'b0, 32'h301, 32'd1, 2'b00, 1'b0);

        repeat (5) @(posedge clk);
        check("b_queue_drained", 64'(exp_b.size()), 64'(0));
        check("r_queue_drained", 64'(exp_r.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_burst_slave_mem.md
Name: axi4_burst_slave_mem

Overview:
- AXI4 (full) burst slave memory that answers the M00_AXI burst master of the tmp IP: it accepts its INCR write bursts, stores them, and returns them on read-back, so the master's compare and ERROR logic can run.
- Replaces the slave VIP in synthesizable loopback builds.
- Independent write and read FSMs share one word-addressed register array.

Parameters:
C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
C_S_AXI_ADDR_WIDTH, 32, byte address width
C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
MEM_DEPTH, 64, number of 32-bit words; power of two

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  reset; one clock; reset is synchronous and active-high
S_AXI_AWID  in  ID  write ID
S_AXI_AWADDR  in  ADDR  write start byte address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  beat size
S_AXI_AWBURST  in  2  burst type
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
S_AXI_BID  out  ID  response ID
S_AXI_BRESP  out  2  write response
S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST  in  ID/ADDR/8/3/2  read address channel
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RID  out  ID  read ID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
ERR_STICKY  out  1  set on any SLVERR issued; cleared only by reset

Behaviour:
- Reset values (while S_AXI_ARESET=1): all READY/VALID outputs 0, BRESP/RRESP 0, RLAST 0, RDATA 0, BID/RID 0, ERR_STICKY 0. Memory contents are not reset.
- First cycle after reset release: AWREADY=1 and ARREADY=1.
- Word index = addr >> 2. Beat is out of range if index >= MEM_DEPTH.

Write FSM, states W_IDLE -> W_DATA -> W_RESP:
- W_IDLE: AWREADY=1. On AWVALID, capture ID, addr, len, size and burst, clear the beat counter and error flag, then go to W_DATA. AWREADY drops the next cycle.
- W_DATA: WREADY=1. Each WVALID&WREADY beat writes the WSTRB-selected bytes to mem[index], the same edge.
- Beat is suppressed (not written) and the error flag is set if any of: AWSIZE!=2, AWBURST is WRAP or reserved, or index out of range.
- Address advance: INCR +4 per beat; FIXED holds.
- Beat count, not WLAST, governs termination. WLAST must equal (count==len); any mismatch sets the error flag.
- After beat len+1, go to W_RESP.
- W_RESP: BVALID=1, BID=captured ID, BRESP=2'b10 if the error flag is set, else 2'b00. Hold until BREADY, then go to W_IDLE. Only one write is outstanding.

Read FSM, states R_IDLE -> R_DATA:
- R_IDLE: ARREADY=1. On ARVALID, capture ARID, addr, len, size and burst, then enter R_DATA the next cycle.
- R_DATA: RVALID=1. RDATA = mem[index] read combinationally from the register array. RID=captured ID. RLAST = (count==len).
- RRESP=2'b10 and RDATA=0 per beat if ARSIZE!=2, burst is WRAP/reserved, or index out of range.
- While RVALID&!RREADY, all R outputs are held stable.
- On handshake, advance addr/count as for writes. After the last beat, go to R_IDLE.
- Same-word read and write in the same cycle: the read returns the old value; the new value is visible the following cycle.

Concurrency and reset:
- Write and read FSMs run concurrently with no ordering between channels.
- ERR_STICKY is set the cycle a SLVERR BRESP or RRESP beat is handshaked.
- Reset mid-burst aborts both FSMs to idle on the next edge. Beats already written stay in memory. No B or R response is issued for the aborted burst.

Test Plan:
- Single burst: reset, then AW addr 0x0, AWLEN=7, INCR, AWID=1, W data 1..8, WSTRB=0xF, BREADY=1 -> BRESP=00, BID=1. AR same -> RDATA 1..8, RLAST only on beat 8, RRESP=00, ERR_STICKY=0.
- Backpressure: BREADY low 5 cycles -> BVALID stays 1 and AWREADY stays 0 until the B handshake. RREADY toggled 1/0 -> RDATA/RLAST stable during stalls, 8 beats delivered in order.
- Byte strobes: write 0x11223344 to 0x20, then 0xAABBCCDD with WSTRB=4'b0101 -> read of 0x20 returns 0x11BB33DD.
- FIXED burst: addr 0x10, AWLEN=3, data A,B,C,D -> mem[4]=D. FIXED read, ARLEN=1 -> RDATA D,D.
- Out of range (MEM_DEPTH=64): AW addr 0xFC, AWLEN=1, data 5,6 -> mem[63]=5, beat 2 suppressed, BRESP=10, ERR_STICKY=1. WLAST asserted on beat 1 of an AWLEN=3 burst -> BRESP=10.
- Reset mid-burst: assert S_AXI_ARESET after 3 of 8 write beats -> next cycle all VALID/READY=0. After release, AWREADY=1, no BVALID, and read-back shows beats 1..3 written.
